mdio_phy_responder: RTL and testbench
=====================================

Name: mdio_phy_responder

Overview:
- Clause-22 MDIO responder (PHY-side management slave) that terminates the management bus driven by the MAC core's MDIO master (mdio_clk/mdio_out/mdio_oen).
- Oversamples MDC and MDIO in the system clock domain and decodes read/write frames addressed to its PHY address.
- Performs accesses through a simple register-port handshake to a local register bank.
- Used in loopback/SGMII bring-up and as the station's far end in simulation.

Parameters:
- P_SYNC_STAGES, 2, synchroniser depth on mdio_clk and mdio_in (min 2).
- P_PREAMBLE_LEN, 32, consecutive 1s required before ST.
- P_BROADCAST_EN, 1'b1, also accept PHYAD 5'd0 for writes; reads to 0 are ignored.

Ports:
- sys_clk  in  1  block clock; must be at least 8x the mdio_clk frequency.
- reset_n  in  1  reset, synchronous, active-low.
- mdio_clk  in  1  MDC from station, asynchronous to sys_clk.
- mdio_in  in  1  MDIO line as seen by the responder.
- mdio_out  out  1  responder drive value.
- mdio_oen  out  1  output enable, active-low: 0 = driving, 1 = released.
- phy_addr  in  5  this responder's PHY address; quasi-static.
- reg_addr  out  5  register address for the current access.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, valid the cycle after reg_rd_en.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wdata  out  16  write data, qualified by reg_wr_en.
- frame_err  out  1  one-cycle pulse on bad ST, invalid OP, or bad write TA.
- busy  out  1  high from ST detection until the frame ends or is aborted.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous, active-low, on sys_clk.
- Reset values:
  - mdio_out=1, mdio_oen=1, reg_rd_en=0, reg_wr_en=0, reg_addr=0, reg_wdata=0, frame_err=0, busy=0.
  - FSM returns to PRE with the preamble count at 0.
  - Reset mid-frame releases the bus in the same cycle reset is sampled; any partial access is discarded.
- Edge detection:
  - mdio_clk and mdio_in pass through P_SYNC_STAGES flops.
  - A rising edge (mdc_rise) is detected as sync==1 and previous==0.
  - All bit processing happens only on mdc_rise cycles, sampling synchronised mdio_in.
- Drive timing:
  - Drive changes are applied on the cycle after mdc_rise, so the station sees valid data at its next rising edge.
- FSM states (bit counter 0..15):
  - PRE: count 1s; a 0 clears the count. Once count>=P_PREAMBLE_LEN (saturating), a 0 moves to ST1.
  - ST1: 1 -> OP; 0 -> pulse frame_err, return to PRE.
  - OP: 2 bits. 10 = read, 01 = write. 00/11 -> frame_err, go to PRE.
  - PHYAD: 5 bits, MSB first.
  - REGAD: 5 bits. On the 5th bit, compute match = (PHYAD==phy_addr) or (P_BROADCAST_EN and PHYAD==0 and write).
    - Read with match: assert reg_rd_en for one cycle with reg_addr; latch reg_rdata on the following cycle.
  - TA: 2 bits.
    - Matched read: bit 1 keeps released; bit 2 drives mdio_oen=0, mdio_out=0.
    - Matched write: sampled bits must be 1,0; otherwise frame_err and abandon to PRE with no write.
  - DATA: 16 bits, MSB first.
    - Read: drive the latched bits sequentially. On the edge after bit 0, release (mdio_oen=1, mdio_out=1).
    - Write: shift in; after the 16th bit, pulse reg_wr_en with reg_addr/reg_wdata for one cycle.
  - Return to PRE with the preamble count at 0 after DATA.
- Non-matching PHYAD: stay released and silently count through TA+DATA (18 edges) back to PRE; no strobes, no frame_err.
- busy: asserted from entering OP until return to PRE.
- Simultaneous events: reset has priority over everything. mdc_rise never coincides with the deferred drive update, because of the sys_clk ratio.

Optional Feature:
- MDIO_PREAMBLE_SUPPRESS_EN:
  - Defined: PRE accepts ST after any 1 (at least one idle bit); the P_PREAMBLE_LEN check is bypassed. Supports stations with preamble suppression.
  - Undefined: the full P_PREAMBLE_LEN preamble is mandatory; shorter preambles are ignored with no frame_err.

Decomposition:
- Package mdio_pkg:
  - state enum (PRE, ST1, OP, PHYAD, REGAD, TA, DATA)
  - op codes (OP_RD=2'b10, OP_WR=2'b01), ST pattern 2'b01, TA pattern 2'b10
  - field widths (5/5/16)
- Sub-module mdio_edge_sync: synchroniser plus rising-edge detector for mdio_clk and mdio_in.

Test Plan:
- Write: phy_addr=5'h01; frame 32x1, ST 01, OP 01, PHYAD 00001, REGAD 00100, TA 10, data 16'hA5C3 -> exactly one reg_wr_en with reg_addr=5'h04, reg_wdata=16'hA5C3; mdio_oen stays 1 throughout.
- Read: same preamble, OP 10, REGAD 00010, reg_rdata=16'h796D -> reg_rd_en once; mdio_oen=0 from TA bit 2 for 17 edges; station samples 0 then 16'h796D MSB-first; bus released afterward.
- Address mismatch: phy_addr=5'h03, read to PHYAD 5'h01 -> no strobes, mdio_oen always 1, busy drops after DATA.
- Errors:
  - OP=11 -> frame_err pulse, no strobes.
  - Write with TA=11 -> frame_err, no reg_wr_en.
  - A following valid write is accepted normally.
- Short preamble (20 ones) then valid write:
  - Without the macro: ignored.
  - With MDIO_PREAMBLE_SUPPRESS_EN: write performed.
- Reset at read DATA bit 8 -> same-cycle mdio_oen=1, busy=0; the next full read completes correctly.

Source files
------------

// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared states, opcodes and field widths for the MDIO responder
package mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_ST1,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } mdio_state_t;

  localparam logic [1:0] OP_RD  = 2'b10;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] ST_PAT = 2'b01;
  localparam logic [1:0] TA_PAT = 2'b10;

  localparam int PHYAD_W = 5;
  localparam int REGAD_W = 5;
  localparam int DATA_W  = 16;

endpackage

// File: rtl/mdio_edge_sync.sv
// rtl/mdio_edge_sync.sv - synchroniser and MDC rising-edge detector
module mdio_edge_sync #(
  parameter int P_SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic reset_n,
  input  logic mdio_clk,
  input  logic mdio_in,
  output logic mdc_rise,
  output logic mdio_bit
);

  logic [P_SYNC_STAGES-1:0] clk_sync;
  logic [P_SYNC_STAGES-1:0] dat_sync;
  logic                     clk_prev;

  // Both lines share one pipeline depth so the sampled bit lines up with the detected edge;
  // flops reset high so a high MDC at reset release never reads as a rising edge.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[P_SYNC_STAGES-2:0], mdio_clk};
      dat_sync <= {dat_sync[P_SYNC_STAGES-2:0], mdio_in};
      clk_prev <= clk_sync[P_SYNC_STAGES-1];
    end
  end

  assign mdc_rise = clk_sync[P_SYNC_STAGES-1] & ~clk_prev;
  assign mdio_bit = dat_sync[P_SYNC_STAGES-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// rtl/mdio_phy_responder.sv - clause-22 MDIO PHY-side responder with local register port
// Build option: MDIO_PREAMBLE_SUPPRESS_EN accepts ST after a single idle 1.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter int   P_SYNC_STAGES  = 2,
  parameter int   P_PREAMBLE_LEN = 32,
  parameter logic P_BROADCAST_EN = 1'b1
) (
  input  logic                sys_clk,
  input  logic                reset_n,
  input  logic                mdio_clk,
  input  logic                mdio_in,
  output logic                mdio_out,
  output logic                mdio_oen,
  input  logic [PHYAD_W-1:0]  phy_addr,
  output logic [REGAD_W-1:0]  reg_addr,
  output logic                reg_rd_en,
  input  logic [DATA_W-1:0]   reg_rdata,
  output logic                reg_wr_en,
  output logic [DATA_W-1:0]   reg_wdata,
  output logic                frame_err,
  output logic                busy
);

  localparam int PC_W = $clog2(P_PREAMBLE_LEN + 1);

  mdio_state_t          state, state_n;
  logic [3:0]           bit_cnt, cnt_n;
  logic [PC_W-1:0]      pre_cnt;
  logic                 pre_ok, pre_sat;
  logic                 mdc_rise, mdio_bit;
  logic                 op_hi, is_rd, ta_hi, addr_hit, rd_lat;
  logic [PHYAD_W-1:0]   phyad;
  logic [REGAD_W-2:0]   regad_lo;
  logic [REGAD_W-1:0]   regad_next;
  logic [DATA_W-2:0]    wr_sh;
  logic [DATA_W-1:0]    wr_word, rd_sh;
  logic                 phy_hit;
  logic                 err_pulse, rd_req, wr_req, addr_load;
  logic                 drv_set, drv_out, drv_oen, drv_shift;

  mdio_edge_sync #(.P_SYNC_STAGES(P_SYNC_STAGES)) u_sync (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .mdio_clk (mdio_clk),
    .mdio_in  (mdio_in),
    .mdc_rise (mdc_rise),
    .mdio_bit (mdio_bit)
  );

  assign pre_sat = (pre_cnt >= PC_W'(P_PREAMBLE_LEN));
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign pre_ok = (pre_cnt != '0);
`else
  assign pre_ok = pre_sat;
`endif

  assign regad_next = {regad_lo, mdio_bit};
  assign wr_word    = {wr_sh, mdio_bit};
  assign phy_hit    = (phyad == phy_addr) || (P_BROADCAST_EN && (phyad == '0) && !is_rd);
  assign busy       = (state != S_PRE) && (state != S_ST1);

  // State and bit counter register
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state   <= S_PRE;
      bit_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
    end
  end

  // Next-state decode plus strobe and drive requests, evaluated only on MDC rising edges
  always_comb begin
    state_n   = state;
    cnt_n     = bit_cnt;
    err_pulse = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    addr_load = 1'b0;
    drv_set   = 1'b0;
    drv_out   = 1'b1;
    drv_oen   = 1'b1;
    drv_shift = 1'b0;
    if (mdc_rise) begin
      cnt_n = bit_cnt + 4'd1;
      case (state)
        S_PRE: begin
          cnt_n = '0;
          if (mdio_bit == ST_PAT[1] && pre_ok) state_n = S_ST1;
        end
        S_ST1: begin
          cnt_n = '0;
          if (mdio_bit == ST_PAT[0]) begin
            state_n = S_OP;
          end else begin
            err_pulse = 1'b1;
            state_n   = S_PRE;
          end
        end
        S_OP: begin
          if (bit_cnt == 4'd1) begin
            cnt_n = '0;
            if ({op_hi, mdio_bit} == OP_RD || {op_hi, mdio_bit} == OP_WR) begin
              state_n = S_PHYAD;
            end else begin
              err_pulse = 1'b1;
              state_n   = S_PRE;
            end
          end
        end
        S_PHYAD: begin
          if (bit_cnt == 4'(PHYAD_W - 1)) begin
            cnt_n   = '0;
            state_n = S_REGAD;
          end
        end
        S_REGAD: begin
          if (bit_cnt == 4'(REGAD_W - 1)) begin
            cnt_n     = '0;
            state_n   = S_TA;
            addr_load = phy_hit;
            rd_req    = phy_hit && is_rd;
          end
        end
        S_TA: begin
          // First TA edge schedules the turnaround 0; second schedules the data MSB.
          if (addr_hit && is_rd) begin
            drv_set   = 1'b1;
            drv_oen   = 1'b0;
            drv_out   = (bit_cnt == 4'd0) ? 1'b0 : rd_sh[DATA_W-1];
            drv_shift = (bit_cnt != 4'd0);
          end
          if (bit_cnt == 4'd1) begin
            cnt_n   = '0;
            state_n = S_DATA;
            if (addr_hit && !is_rd && ({ta_hi, mdio_bit} != TA_PAT)) begin
              err_pulse = 1'b1;
              state_n   = S_PRE;
            end
          end
        end
        S_DATA: begin
          if (addr_hit && is_rd) begin
            drv_set = 1'b1;
            if (bit_cnt != 4'(DATA_W - 1)) begin
              drv_oen   = 1'b0;
              drv_out   = rd_sh[DATA_W-1];
              drv_shift = 1'b1;
            end
          end
          if (bit_cnt == 4'(DATA_W - 1)) begin
            cnt_n   = '0;
            state_n = S_PRE;
            wr_req  = addr_hit && !is_rd;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = S_PRE;
        end
      endcase
    end
  end

  // Field shift registers, preamble counter, register-port strobes and line drive
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      pre_cnt   <= '0;
      op_hi     <= 1'b0;
      is_rd     <= 1'b0;
      ta_hi     <= 1'b0;
      addr_hit  <= 1'b0;
      rd_lat    <= 1'b0;
      phyad     <= '0;
      regad_lo  <= '0;
      wr_sh     <= '0;
      rd_sh     <= '0;
      mdio_out  <= 1'b1;
      mdio_oen  <= 1'b1;
      reg_addr  <= '0;
      reg_rd_en <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      reg_rd_en <= rd_req;
      reg_wr_en <= wr_req;
      frame_err <= err_pulse;
      rd_lat    <= reg_rd_en;
      if (mdc_rise) begin
        case (state)
          S_PRE:   pre_cnt <= mdio_bit ? (pre_sat ? pre_cnt : pre_cnt + PC_W'(1)) : '0;
          S_OP:    if (bit_cnt == 4'd0) op_hi <= mdio_bit;
                   else is_rd <= ({op_hi, mdio_bit} == OP_RD);
          S_PHYAD: phyad <= {phyad[PHYAD_W-2:0], mdio_bit};
          S_REGAD: begin
            regad_lo <= regad_next[REGAD_W-2:0];
            if (bit_cnt == 4'(REGAD_W - 1)) addr_hit <= phy_hit;
          end
          S_TA:    if (bit_cnt == 4'd0) ta_hi <= mdio_bit;
          S_DATA:  wr_sh <= wr_word[DATA_W-2:0];
          default: ;
        endcase
      end
      if (state != S_PRE) pre_cnt <= '0;
      if (addr_load) reg_addr <= regad_next;
      if (wr_req) reg_wdata <= wr_word;
      if (rd_lat) rd_sh <= reg_rdata;
      else if (drv_shift) rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};
      if (drv_set) begin
        mdio_out <= drv_out;
        mdio_oen <= drv_oen;
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb/tb_mdio_phy_responder.sv - self-checking bench with a station model and frame-level reference
module tb_mdio_phy_responder;

  localparam int K_NONE = 0;
  localparam int K_WR   = 1;
  localparam int K_RD   = 2;
  localparam int K_ERR  = 3;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mdio_clk = 1'b0;
  logic        mdio_in;
  logic        mdio_out, mdio_oen;
  logic [4:0]  phy_addr = 5'h01;
  logic [4:0]  reg_addr;
  logic        reg_rd_en, reg_wr_en, frame_err, busy;
  logic [15:0] reg_rdata = 16'h0000;
  logic [15:0] reg_wdata;

  logic        st_oe = 1'b1;
  logic        st_val = 1'b1;
  logic [15:0] bank [32];

  int total = 0;
  int bad = 0;
  int wr_cnt = 0, rd_cnt = 0, err_cnt = 0, oen_low_cyc = 0, busy_cyc = 0;
  int s_wr, s_rd, s_err, s_oen, s_busy;
  logic [4:0]  w_addr = '0, r_addr = '0;
  logic [15:0] w_data = '0;
  int          low_edges;
  logic [16:0] cap;

  always #5 sys_clk = ~sys_clk;

  // Shared line: station when it drives, else the responder, else the pull-up.
  assign mdio_in = st_oe ? st_val : (mdio_oen ? 1'b1 : mdio_out);

  mdio_phy_responder dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .mdio_clk  (mdio_clk),
    .mdio_in   (mdio_in),
    .mdio_out  (mdio_out),
    .mdio_oen  (mdio_oen),
    .phy_addr  (phy_addr),
    .reg_addr  (reg_addr),
    .reg_rd_en (reg_rd_en),
    .reg_rdata (reg_rdata),
    .reg_wr_en (reg_wr_en),
    .reg_wdata (reg_wdata),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Register bank returns data one cycle after the strobe, junk otherwise
  always @(posedge sys_clk) reg_rdata <= reg_rd_en ? bank[reg_addr] : 16'($urandom);

  // Strobe and bus-activity monitor
  always @(negedge sys_clk) begin
    if (reg_wr_en) begin wr_cnt++; w_addr = reg_addr; w_data = reg_wdata; end
    if (reg_rd_en) begin rd_cnt++; r_addr = reg_addr; end
    if (frame_err) err_cnt++;
    if (!mdio_oen) oen_low_cyc++;
    if (busy) busy_cyc++;
  end

  task automatic snap();
    @(posedge sys_clk);
    s_wr = wr_cnt; s_rd = rd_cnt; s_err = err_cnt; s_oen = oen_low_cyc; s_busy = busy_cyc;
  endtask

  task automatic settle();
    repeat (4) @(posedge sys_clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic drive);
    st_oe  = drive;
    st_val = b;
    #80;
    mdio_clk = 1'b1;
    if (!mdio_oen) begin
      low_edges++;
      cap = {cap[15:0], mdio_in};
    end
    #80;
    mdio_clk = 1'b0;
  endtask

  task automatic send_frame(input int pre_len, input logic [1:0] op, input logic [4:0] pa,
                            input logic [4:0] ra, input logic [1:0] ta, input logic [15:0] d,
                            input int limit);
    logic q[$];
    int   ta_idx;
    for (int i = 0; i < pre_len; i++) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b1);
    q.push_back(op[1]);
    q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(pa[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    ta_idx = q.size();
    q.push_back(ta[1]);
    q.push_back(ta[0]);
    for (int i = 15; i >= 0; i--) q.push_back(d[i]);
    low_edges = 0;
    cap = '0;
    @(negedge sys_clk);
    for (int i = 0; i < q.size() && i < limit; i++)
      send_bit(q[i], !(op == 2'b10 && i >= ta_idx));
    st_oe  = 1'b1;
    st_val = 1'b1;
  endtask

  // Frame outcome from the protocol rules alone
  function automatic int frame_kind(input logic [1:0] op, input logic [4:0] fpa,
                                    input logic [1:0] ta, input logic [4:0] pa);
    logic hit;
    if (op != 2'b10 && op != 2'b01) return K_ERR;
    hit = (fpa == pa) || (fpa == 5'd0 && op == 2'b01);
    if (!hit) return K_NONE;
    if (op == 2'b01) return (ta == 2'b10) ? K_WR : K_ERR;
    return K_RD;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1;
    total++;
    if ({mdio_out, mdio_oen, reg_rd_en, reg_wr_en, frame_err, busy} !== 6'b110000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=110000", {mdio_out, mdio_oen, reg_rd_en, reg_wr_en, frame_err, busy});
    end
    total++;
    if (reg_addr !== 5'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", reg_addr); end
    total++;
    if (reg_wdata !== 16'h0000) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", reg_wdata); end
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (4) @(posedge sys_clk);
  endtask

  task automatic test_write();
    phy_addr = 5'h01;
    snap();
    send_frame(32, 2'b01, 5'h01, 5'h04, 2'b10, 16'hA5C3, 999);
    settle();
    total++;
    if (wr_cnt - s_wr !== 1) begin bad++; $display("FAIL wr_count got=%0d exp=1", wr_cnt - s_wr); end
    total++;
    if (w_addr !== 5'h04) begin bad++; $display("FAIL wr_addr got=%h exp=04", w_addr); end
    total++;
    if (w_data !== 16'hA5C3) begin bad++; $display("FAIL wr_data got=%h exp=a5c3", w_data); end
    total++;
    if (oen_low_cyc - s_oen !== 0) begin bad++; $display("FAIL wr_oen got=%0d exp=0", oen_low_cyc - s_oen); end
    total++;
    if ((rd_cnt - s_rd) + (err_cnt - s_err) !== 0) begin
      bad++; $display("FAIL wr_other got=%0d exp=0", (rd_cnt - s_rd) + (err_cnt - s_err));
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    phy_addr = 5'h01;
    snap();
    send_frame(32, 2'b10, 5'h01, 5'h02, 2'b11, 16'hFFFF, 999);
    settle();
    total++;
    if (rd_cnt - s_rd !== 1) begin bad++; $display("FAIL rd_count got=%0d exp=1", rd_cnt - s_rd); end
    total++;
    if (r_addr !== 5'h02) begin bad++; $display("FAIL rd_addr got=%h exp=02", r_addr); end
    total++;
    if (low_edges !== 17) begin bad++; $display("FAIL rd_drive_edges got=%0d exp=17", low_edges); end
    total++;
    if (cap !== {1'b0, 16'h796D}) begin bad++; $display("FAIL rd_data got=%h exp=%h", cap, {1'b0, 16'h796D}); end
    total++;
    if (mdio_oen !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rd_release got=oen%b/busy%b exp=oen1/busy0", mdio_oen, busy);
    end
  endtask

  task automatic test_mismatch();
    phy_addr = 5'h03;
    snap();
    send_frame(32, 2'b10, 5'h01, 5'h02, 2'b11, 16'hFFFF, 999);
    settle();
    total++;
    if ((wr_cnt - s_wr) + (rd_cnt - s_rd) + (err_cnt - s_err) !== 0) begin
      bad++; $display("FAIL mm_strobes got=%0d exp=0", (wr_cnt - s_wr) + (rd_cnt - s_rd) + (err_cnt - s_err));
    end
    total++;
    if (oen_low_cyc - s_oen !== 0) begin bad++; $display("FAIL mm_oen got=%0d exp=0", oen_low_cyc - s_oen); end
    total++;
    if (busy_cyc - s_busy < 100) begin bad++; $display("FAIL mm_busy_seen got=%0d exp>=100", busy_cyc - s_busy); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mm_busy_end got=%b exp=0", busy); end
    phy_addr = 5'h01;
  endtask

  task automatic test_errors();
    phy_addr = 5'h01;
    snap();
    send_frame(32, 2'b11, 5'h1F, 5'h1F, 2'b11, 16'hFFFF, 999);
    settle();
    total++;
    if (err_cnt - s_err !== 1) begin bad++; $display("FAIL err_op got=%0d exp=1", err_cnt - s_err); end
    total++;
    if ((wr_cnt - s_wr) + (rd_cnt - s_rd) !== 0) begin
      bad++; $display("FAIL err_op_strobes got=%0d exp=0", (wr_cnt - s_wr) + (rd_cnt - s_rd));
    end
    snap();
    send_frame(32, 2'b01, 5'h01, 5'h07, 2'b11, 16'hFFFF, 999);
    settle();
    total++;
    if (err_cnt - s_err !== 1) begin bad++; $display("FAIL err_ta got=%0d exp=1", err_cnt - s_err); end
    total++;
    if (wr_cnt - s_wr !== 0) begin bad++; $display("FAIL err_ta_wr got=%0d exp=0", wr_cnt - s_wr); end
    snap();
    send_frame(32, 2'b01, 5'h01, 5'h07, 2'b10, 16'h1234, 999);
    settle();
    total++;
    if (wr_cnt - s_wr !== 1 || w_addr !== 5'h07 || w_data !== 16'h1234) begin
      bad++; $display("FAIL err_recover got=%0d/%h/%h exp=1/07/1234", wr_cnt - s_wr, w_addr, w_data);
    end
    total++;
    if (err_cnt - s_err !== 0) begin bad++; $display("FAIL err_recover_err got=%0d exp=0", err_cnt - s_err); end
  endtask

  task automatic test_short_preamble();
    int exp_wr;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    exp_wr = 1;
`else
    exp_wr = 0;
`endif
    phy_addr = 5'h01;
    snap();
    send_frame(20, 2'b01, 5'h01, 5'h09, 2'b10, 16'h0F0F, 999);
    settle();
    total++;
    if (wr_cnt - s_wr !== exp_wr) begin bad++; $display("FAIL short_pre_wr got=%0d exp=%0d", wr_cnt - s_wr, exp_wr); end
    total++;
    if (err_cnt - s_err !== 0) begin bad++; $display("FAIL short_pre_err got=%0d exp=0", err_cnt - s_err); end
  endtask

  task automatic test_reset_mid_read();
    phy_addr = 5'h01;
    bank[5] = 16'($urandom);
    send_frame(32, 2'b10, 5'h01, 5'h05, 2'b11, 16'hFFFF, 32 + 2 + 2 + 10 + 2 + 8);
    total++;
    if (mdio_oen !== 1'b0) begin bad++; $display("FAIL mid_driving got=%b exp=0", mdio_oen); end
    @(negedge sys_clk);
    reset_n = 1'b0;
    @(posedge sys_clk);
    #1;
    total++;
    if (mdio_oen !== 1'b1 || mdio_out !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=oen%b/out%b/busy%b exp=oen1/out1/busy0", mdio_oen, mdio_out, busy);
    end
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    snap();
    send_frame(32, 2'b10, 5'h01, 5'h05, 2'b11, 16'hFFFF, 999);
    settle();
    total++;
    if (rd_cnt - s_rd !== 1 || low_edges !== 17 || cap !== {1'b0, bank[5]}) begin
      bad++; $display("FAIL mid_next_read got=%0d/%0d/%h exp=1/17/%h", rd_cnt - s_rd, low_edges, cap, {1'b0, bank[5]});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      logic [4:0]  pa, fpa, ra;
      logic [1:0]  op, ta;
      logic [15:0] d;
      int          kind, sel;
      pa  = 5'($urandom_range(1, 31));
      sel = $urandom_range(0, 3);
      fpa = (sel == 1) ? 5'd0 : (sel == 2) ? 5'($urandom) : pa;
      sel = $urandom_range(0, 5);
      op  = (sel < 2) ? 2'b01 : (sel < 4) ? 2'b10 : (sel == 4) ? 2'b00 : 2'b11;
      ta  = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
      ra  = 5'($urandom);
      d   = 16'($urandom);
      kind = frame_kind(op, fpa, ta, pa);
      if (kind == K_ERR) begin
        d = 16'hFFFF;
        if (op != 2'b01) begin fpa = 5'h1F; ra = 5'h1F; ta = 2'b11; end
      end
      phy_addr = pa;
      snap();
      send_frame(32, op, fpa, ra, ta, d, 999);
      settle();
      total++;
      if (wr_cnt - s_wr !== ((kind == K_WR) ? 1 : 0)) begin
        bad++; $display("FAIL rnd%0d_wr got=%0d exp=%0d", n, wr_cnt - s_wr, (kind == K_WR) ? 1 : 0);
      end
      total++;
      if (rd_cnt - s_rd !== ((kind == K_RD) ? 1 : 0)) begin
        bad++; $display("FAIL rnd%0d_rd got=%0d exp=%0d", n, rd_cnt - s_rd, (kind == K_RD) ? 1 : 0);
      end
      total++;
      if (err_cnt - s_err !== ((kind == K_ERR) ? 1 : 0)) begin
        bad++; $display("FAIL rnd%0d_err got=%0d exp=%0d", n, err_cnt - s_err, (kind == K_ERR) ? 1 : 0);
      end
      if (kind == K_WR) begin
        total++;
        if (w_addr !== ra || w_data !== d) begin
          bad++; $display("FAIL rnd%0d_wdata got=%h/%h exp=%h/%h", n, w_addr, w_data, ra, d);
        end
      end
      if (kind == K_RD) begin
        total++;
        if (low_edges !== 17 || cap !== {1'b0, bank[ra]}) begin
          bad++; $display("FAIL rnd%0d_rdata got=%0d/%h exp=17/%h", n, low_edges, cap, {1'b0, bank[ra]});
        end
      end else begin
        total++;
        if (oen_low_cyc - s_oen !== 0) begin bad++; $display("FAIL rnd%0d_oen got=%0d exp=0", n, oen_low_cyc - s_oen); end
      end
      total++;
      if (busy !== 1'b0 || mdio_oen !== 1'b1) begin
        bad++; $display("FAIL rnd%0d_idle got=busy%b/oen%b exp=busy0/oen1", n, busy, mdio_oen);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 16'($urandom);
    bank[2] = 16'h796D;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_errors();
    test_short_preamble();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
